// File: rtl/mul_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_hilo_unit
//  Description : Unsigned sequential shift-add multiplier with HI/LO result
//                registers and a combinational MFHI/MFLO read port.
//                One product bit per clock: WIDTH iterations, then a FINISH
//                cycle that writes HI/LO and pulses done.
//  Ports       : clk     - clock, rising edge
//                reset   - asynchronous active-high reset
//                start   - one-cycle request, accepted only in IDLE
//                op      - function code (MULTU / MFHI / MFLO / others)
//                dataA   - multiplicand (unsigned), sampled at start
//                dataB   - multiplier (unsigned), sampled at start
//                busy    - high in RUN and FINISH
//                done    - one-cycle pulse when HI/LO are written
//                hi, lo  - current HI / LO registers
//                dataOut - hi for MFHI, lo for MFLO, else 0
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] dataOut
);

    localparam logic [5:0] c_OP_MULTU = 6'b011001;
    localparam logic [5:0] c_OP_MFHI  = 6'b010000;
    localparam logic [5:0] c_OP_MFLO  = 6'b010010;

    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH:0]     r_prod;   // {carry, upper, lower}
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH:0]     w_prod_next;

    // The carry bit is always 0 here because every shift clears it, so
    // {carry, upper} is the zero-extended upper half; the WIDTH+1 bit sum
    // then keeps the carry-out of the add until the shift consumes it.
    always_comb begin
        w_sum = r_prod[2*WIDTH:WIDTH];
        if (r_prod[0]) begin
            w_sum = r_prod[2*WIDTH:WIDTH] + {1'b0, r_mcand};
        end
        w_prod_next = {1'b0, w_sum, r_prod[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_prod  <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && (op == c_OP_MULTU)) begin
                        r_mcand <= dataA;
                        r_prod  <= {1'b0, {WIDTH{1'b0}}, dataB};
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_prod  <= w_prod_next;
                    r_count <= r_count + c_CNT_W'(1);
                    if (r_count == c_LAST) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_hi    <= r_prod[2*WIDTH-1:WIDTH];
                    r_lo    <= r_prod[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dataOut = '0;
        case (op)
            c_OP_MFHI: dataOut = r_hi;
            c_OP_MFLO: dataOut = r_lo;
            default:   dataOut = '0;
        endcase
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_hilo_unit
//  Description : Self-checking bench for mul_hilo_unit. Expected products
//                are queued when a multiply is launched and compared when
//                done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_hilo_unit;

    localparam int         WIDTH      = 32;
    localparam logic [5:0] c_OP_MULTU = 6'b011001;
    localparam logic [5:0] c_OP_MFHI  = 6'b010000;
    localparam logic [5:0] c_OP_MFLO  = 6'b010010;
    localparam logic [5:0] c_OP_ADD   = 6'b100000;

    logic             clk;
    logic             reset;
    logic             start;
    logic [5:0]       op;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] dataOut;

    int          n_cmp  = 0;
    int          n_err  = 0;
    int          n_done = 0;
    logic [63:0] sb[$];

    mul_hilo_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .dataA   (dataA),
        .dataB   (dataB),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .dataOut (dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued product.
    always @(negedge clk) begin
        if (done) begin
            logic [63:0] e;
            n_done++;
            if (sb.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("sb_hi", 64'(hi), 64'(e[63:32]));
                check("sb_lo", 64'(lo), 64'(e[31:0]));
            end
        end
    end

    // Launch one multiply, scramble operands afterwards, and check latency,
    // busy width and the done fall.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b);
        int lat;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; op = c_OP_MULTU; dataA = a; dataB = b;
        sb.push_back(64'(a) * 64'(b));
        @(posedge clk); #1;
        start = 1'b0; op = c_OP_MFLO; dataA = $urandom; dataB = $urandom;
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cnt++;
        end
        if (lat == 0) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            check("latency", 64'(lat), 64'd33);
            check("busy_cycles", 64'(busy_cnt), 64'd33);
            check("busy_clear", 64'(busy), 64'd0);
            @(posedge clk); #1;
            check("done_fall", 64'(done), 64'd0);
        end
    endtask

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; op = 6'd0; dataA = '0; dataB = '0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        @(negedge clk); reset = 1'b0;

        // 7*6 and read back through MFLO
        run_mul(32'd7, 32'd6);
        op = c_OP_MFLO; #1;
        check("mflo_42", 64'(dataOut), 64'd42);
        check("hi_0", 64'(hi), 64'd0);

        // start with ADD: no effect, reads 0
        @(negedge clk); start = 1'b1; op = c_OP_ADD;
        #1 check("add_dout", 64'(dataOut), 64'd0);
        @(posedge clk); #1; start = 1'b0;
        check("add_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk); #1;
        check("add_hi", 64'(hi), 64'd0);
        check("add_lo", 64'(lo), 64'd42);
        op = 6'b111111; #1;
        check("op3f_dout", 64'(dataOut), 64'd0);

        // all-ones operands
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op = c_OP_MFHI; #1;
        check("mfhi_ff", 64'(dataOut), 64'hFFFF_FFFE);

        // 3*5 with a second start (and new operands) at edge 10
        d0 = n_done;
        @(negedge clk); start = 1'b1; op = c_OP_MULTU; dataA = 32'd3; dataB = 32'd5;
        sb.push_back(64'd15);
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); start = 1'b1; op = c_OP_MULTU; dataA = 32'd9; dataB = 32'd9;
        @(posedge clk); #1; start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("ign_done_cnt", 64'(n_done - d0), 64'd1);
        check("ign_lo", 64'(lo), 64'd15);
        check("ign_busy", 64'(busy), 64'd0);

        // reset mid-RUN aborts the multiply; dataOut shows old product in RUN
        d0 = n_done;
        @(negedge clk); start = 1'b1; op = c_OP_MULTU; dataA = 32'h10000; dataB = 32'h10000;
        @(posedge clk); #1; start = 1'b0; op = c_OP_MFLO;
        repeat (9) @(posedge clk);
        #1;
        check("run_dout_prev", 64'(dataOut), 64'd15);
        check("run_busy", 64'(busy), 64'd1);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi",   64'(hi),   64'd0);
        check("abort_lo",   64'(lo),   64'd0);
        @(negedge clk); reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", 64'(n_done - d0), 64'd0);

        run_mul(32'd2, 32'd3);
        check("after_rst_lo", 64'(lo), 64'd6);

        // zero multiplicand still takes the full latency
        run_mul(32'd0, 32'hFFFF_FFFF);

        for (int i = 0; i < 3; i++) begin
            run_mul($urandom, $urandom);
        end

        repeat (3) @(posedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
